// File: rtl/pipe_credit_fifo.sv
// ---------------------------------------------------------------------------
// pipe_credit_fifo
//
// Credit-managed landing FIFO at the end of a fixed-delay pipeline. Upstream
// may launch an item whenever issue_ok_o is high; the item reappears LAT
// cycles later on pv_i/pd_i and is captured here. A credit is outstanding for
// every item either stored in the FIFO or still travelling down the pipeline,
// so a well-behaved upstream can never overflow the storage.
//
// Ports
//   clk         : clock, all state updates on the rising edge
//   rst_n       : synchronous active-low reset
//   issue_i     : upstream launched one item this cycle
//   issue_ok_o  : a credit is free, upstream may issue this cycle
//   pv_i, pd_i  : valid / data arriving from the end of the pipeline
//   ov_o, od_o  : output valid / head data (first-word-fall-through)
//   ordy_i      : downstream accepts od_o
//   count_o     : entries held in the FIFO
//   inflight_o  : issued items that have not arrived yet
//   err_o       : sticky errors
//                 [0] issue without credit
//                 [1] arrival dropped because the FIFO was full
//                 [2] arrival while nothing was in flight
// ---------------------------------------------------------------------------
module pipe_credit_fifo #(
    parameter int WID   = 32,
    parameter int DEPTH = 8,
    parameter int LAT   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       issue_i,
    output logic                       issue_ok_o,
    input  logic                       pv_i,
    input  logic [WID-1:0]             pd_i,
    output logic                       ov_o,
    output logic [WID-1:0]             od_o,
    input  logic                       ordy_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [$clog2(DEPTH):0]     inflight_o,
    output logic [2:0]                 err_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // LAT only documents the upstream pipeline; it is checked here so that a
    // nonsensical configuration is caught at elaboration.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || LAT < 1) begin : g_bad_param
        $error("pipe_credit_fifo: DEPTH must be a power of two >= 2 and LAT >= 1");
    end

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [WID-1:0] mem [DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q, inflight_q;
    logic [2:0]     err_q;

    // Next-state
    logic [AW-1:0]  wr_ptr_d, rd_ptr_d;
    logic [CW-1:0]  count_d, inflight_d;
    logic [2:0]     err_d;

    logic           full;
    logic           pop;
    logic           push;
    logic [CW:0]    credit_sum;

    // -----------------------------------------------------------------------
    // Outputs: everything is a function of registered state only, so there is
    // no combinational path from any input to any output.
    // -----------------------------------------------------------------------
    assign credit_sum = {1'b0, count_q} + {1'b0, inflight_q};
    assign issue_ok_o = (credit_sum < (CW + 1)'(DEPTH));
    assign ov_o       = (count_q != '0);
    assign od_o       = mem[rd_ptr_q];
    assign count_o    = count_q;
    assign inflight_o = inflight_q;
    assign err_o      = err_q;

    // -----------------------------------------------------------------------
    // Handshake decode. A push into a full FIFO is still accepted when the
    // head leaves on the same edge, because the freed slot is reused.
    // -----------------------------------------------------------------------
    assign full = (count_q == FULL_CNT);
    assign pop  = ov_o & ordy_i;
    assign push = pv_i & (~full | pop);

    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path leaves it unassigned, which would otherwise infer a latch.
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        inflight_d = inflight_q;
        err_d      = err_q;

        // Pointers wrap naturally because DEPTH is a power of two.
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // An issue and an arrival on the same edge cancel out. A lone issue
        // saturates at DEPTH (only reachable when upstream ignores credits);
        // a lone arrival with nothing in flight leaves the counter at zero.
        unique case ({issue_i, pv_i})
            2'b10: begin
                if (inflight_q != FULL_CNT) inflight_d = inflight_q + 1'b1;
            end
            2'b01: begin
                if (inflight_q != '0) inflight_d = inflight_q - 1'b1;
            end
            default: inflight_d = inflight_q;
        endcase

        err_d = err_q | {pv_i & (inflight_q == '0),
                         pv_i & full & ~pop,
                         issue_i & ~issue_ok_o};
    end

    // -----------------------------------------------------------------------
    // Control registers with synchronous reset. Reset wins over any
    // concurrent issue, arrival or pop; in-flight items are forgotten.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every register samples the pre-edge values of the others.
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            err_q      <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    // -----------------------------------------------------------------------
    // Storage
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: the data array is deliberately not reset; validity is tracked
        // by count_q alone, and leaving it unreset lets it map onto RAM.
        if (rst_n && push) mem[wr_ptr_q] <= pd_i;
    end

endmodule
